// File: rtl/pixel_stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_packer_if
// Brief    : Pixel input and AXI4-Stream video output bundle of the packer.
// Revision : 1.0  initial release
// ============================================================================
interface pixel_stream_packer_if #(
    parameter int PIX_WIDTH = 24
) ();
    logic [PIX_WIDTH-1:0] pixel_in;
    logic                 valid_in;
    logic                 in_ready;
    logic [PIX_WIDTH-1:0] out_tdata;
    logic                 out_tvalid;
    logic                 out_tready;
    logic                 out_tlast;
    logic                 out_tuser;

    // Producer/sink side: shading stage upstream plus the VDMA sink.
    modport master (
        output pixel_in,
        output valid_in,
        output out_tready,
        input  in_ready,
        input  out_tdata,
        input  out_tvalid,
        input  out_tlast,
        input  out_tuser
    );

    modport slave (
        input  pixel_in,
        input  valid_in,
        input  out_tready,
        output in_ready,
        output out_tdata,
        output out_tvalid,
        output out_tlast,
        output out_tuser
    );
endinterface
`default_nettype wire

// File: rtl/pixel_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_packer
// Brief    : FWFT pixel FIFO feeding an AXI4-Stream video output with
//            tuser (start of frame) and tlast (end of line) framing.
// Revision : 1.0  initial release
// ============================================================================
module pixel_stream_packer #(
    parameter int PIX_WIDTH  = 24,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    pixel_stream_packer_if.slave               bus,
    output logic                               frame_done,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH):0]        fill_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] c_DEPTH  = CW'(FIFO_DEPTH);
    localparam logic [XW-1:0] c_X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(IMG_H - 1);

    logic [PIX_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic                 r_frame_done;
    logic                 r_overflow;

    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_wr;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_rd    = !w_empty && bus.out_tready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_wr    = bus.valid_in && (!w_full || w_rd);
    assign w_drop  = bus.valid_in && w_full && !w_rd;

    // Storage carries no reset: contents are only observable behind r_count.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Raster position of the pixel currently at the FIFO head; moves on beats only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_rd) begin
                if (r_x == c_X_LAST) begin
                    r_x <= '0;
                    if (r_y == c_Y_LAST) begin
                        r_y          <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_y <= r_y + YW'(1);
                    end
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.out_tvalid = !w_empty;
    assign bus.out_tdata  = r_mem[r_rd_ptr];
    assign bus.out_tlast  = !w_empty && (r_x == c_X_LAST);
    assign bus.out_tuser  = !w_empty && (r_x == '0) && (r_y == '0);

    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign fill_level = r_count;
endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_packer
// Brief    : Directed vector table plus hand-written FIFO corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_stream_packer;
    localparam int PW    = 24;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_done;
    logic       overflow;
    logic [4:0] fill_level;

    int n_cmp = 0;
    int n_err = 0;

    pixel_stream_packer_if #(.PIX_WIDTH(PW)) bus_if ();

    pixel_stream_packer #(
        .PIX_WIDTH  (PW),
        .IMG_W      (4),
        .IMG_H      (2),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .frame_done (frame_done),
        .overflow   (overflow),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          valid;
        logic [PW-1:0] pix;
        logic          tready;
        logic          ev;
        logic [PW-1:0] ed;
        logic          el;
        logic          eu;
        logic [4:0]    ef;
        logic          efd;
    } vec_t;

    vec_t          vecs[14];
    logic [PW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic r, logic v, logic [PW-1:0] p, logic tr, logic ev,
                                logic [PW-1:0] ed, logic el, logic eu, logic [4:0] ef, logic efd);
        vec_t t;
        t.rst = r; t.valid = v; t.pix = p; t.tready = tr; t.ev = ev;
        t.ed = ed; t.el = el; t.eu = eu; t.ef = ef; t.efd = efd;
        return t;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus_if.valid_in   = 1'b0;
        bus_if.out_tready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Consume n beats with tready held high, checking order against exp_q.
    task automatic drain(input int n, input string tag);
        bus_if.valid_in   = 1'b0;
        bus_if.out_tready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_tvalid"}, 32'(bus_if.out_tvalid), 32'd1);
            if (exp_q.size() > 0) begin
                chk({tag, "_tdata"}, 32'(bus_if.out_tdata), 32'(exp_q.pop_front()));
            end
            step();
        end
        bus_if.out_tready = 1'b0;
    endtask

    task automatic fill_stalled(input logic [PW-1:0] base, input int n);
        bus_if.out_tready = 1'b0;
        bus_if.valid_in   = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus_if.pixel_in = base + PW'(i);
            exp_q.push_back(base + PW'(i));
            step();
        end
        bus_if.valid_in = 1'b0;
    endtask

    initial begin
        // Rows 0-2: reset and single-pixel pass-through.
        vecs[0] = mk(1, 0, 24'h0,      0, 0, 24'h0,      0, 0, 5'd0, 0);
        vecs[1] = mk(0, 1, 24'h123456, 1, 1, 24'h123456, 0, 1, 5'd1, 0);
        vecs[2] = mk(0, 0, 24'h0,      1, 0, 24'h0,      0, 0, 5'd0, 0);
        vecs[3] = mk(1, 0, 24'h0,      0, 0, 24'h0,      0, 0, 5'd0, 0);
        // Rows 4-12: continuous 4x2 frame; row shows head pixel k after edge k.
        vecs[4]  = mk(0, 1, 24'hA00000, 1, 1, 24'hA00000, 0, 1, 5'd1, 0);
        vecs[5]  = mk(0, 1, 24'hA00001, 1, 1, 24'hA00001, 0, 0, 5'd1, 0);
        vecs[6]  = mk(0, 1, 24'hA00002, 1, 1, 24'hA00002, 0, 0, 5'd1, 0);
        vecs[7]  = mk(0, 1, 24'hA00003, 1, 1, 24'hA00003, 1, 0, 5'd1, 0);
        vecs[8]  = mk(0, 1, 24'hA00004, 1, 1, 24'hA00004, 0, 0, 5'd1, 0);
        vecs[9]  = mk(0, 1, 24'hA00005, 1, 1, 24'hA00005, 0, 0, 5'd1, 0);
        vecs[10] = mk(0, 1, 24'hA00006, 1, 1, 24'hA00006, 0, 0, 5'd1, 0);
        vecs[11] = mk(0, 1, 24'hA00007, 1, 1, 24'hA00007, 1, 0, 5'd1, 0);
        vecs[12] = mk(0, 1, 24'hA00008, 1, 1, 24'hA00008, 0, 1, 5'd1, 1);
        vecs[13] = mk(0, 0, 24'h0,      1, 0, 24'h0,      0, 0, 5'd0, 0);

        rst               = 1'b1;
        bus_if.valid_in   = 1'b0;
        bus_if.pixel_in   = '0;
        bus_if.out_tready = 1'b0;

        for (int i = 0; i < 14; i++) begin
            rst               = vecs[i].rst;
            bus_if.valid_in   = vecs[i].valid;
            bus_if.pixel_in   = vecs[i].pix;
            bus_if.out_tready = vecs[i].tready;
            step();
            chk($sformatf("v%0d_tvalid", i), 32'(bus_if.out_tvalid), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_tdata", i), 32'(bus_if.out_tdata), 32'(vecs[i].ed));
            end
            chk($sformatf("v%0d_tlast", i), 32'(bus_if.out_tlast), 32'(vecs[i].el));
            chk($sformatf("v%0d_tuser", i), 32'(bus_if.out_tuser), 32'(vecs[i].eu));
            chk($sformatf("v%0d_fill", i), 32'(fill_level), 32'(vecs[i].ef));
            chk($sformatf("v%0d_in_ready", i), 32'(bus_if.in_ready), 32'(vecs[i].ef != 5'd16));
            chk($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'(vecs[i].efd));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'd0);
        end
        rst = 1'b0;

        // Backpressure: fill to depth, head holds the first pixel.
        do_reset();
        exp_q.delete();
        fill_stalled(24'hB00000, DEPTH);
        chk("bp_fill", 32'(fill_level), 32'd16);
        chk("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("bp_head", 32'(bus_if.out_tdata), 32'hB00000);
        step();
        chk("bp_hold", 32'(bus_if.out_tdata), 32'hB00000);

        // Full with simultaneous read and write for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            bus_if.valid_in   = 1'b1;
            bus_if.pixel_in   = 24'hC00000 + PW'(i);
            bus_if.out_tready = 1'b1;
            chk($sformatf("rw%0d_head", i), 32'(bus_if.out_tdata), 32'(exp_q.pop_front()));
            exp_q.push_back(24'hC00000 + PW'(i));
            step();
            chk($sformatf("rw%0d_fill", i), 32'(fill_level), 32'd16);
            chk($sformatf("rw%0d_overflow", i), 32'(overflow), 32'd0);
        end
        drain(DEPTH, "bp_drain");
        chk("bp_empty", 32'(bus_if.out_tvalid), 32'd0);
        chk("bp_ovf", 32'(overflow), 32'd0);

        // Overflow: one write too many while stalled is dropped.
        do_reset();
        exp_q.delete();
        fill_stalled(24'hD00000, DEPTH);
        bus_if.valid_in = 1'b1;
        bus_if.pixel_in = 24'hDEAD01;
        step();
        bus_if.valid_in = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_fill", 32'(fill_level), 32'd16);
        drain(DEPTH, "ovf_drain");
        chk("ovf_no_extra", 32'(bus_if.out_tvalid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Mid-frame reset after 3 beats with 5 pixels still buffered.
        exp_q.delete();
        fill_stalled(24'hE00000, 8);
        bus_if.out_tready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus_if.out_tready = 1'b0;
        chk("mf_fill", 32'(fill_level), 32'd5);
        chk("mf_head", 32'(bus_if.out_tdata), 32'hE00003);
        chk("mf_tlast", 32'(bus_if.out_tlast), 32'd1);
        do_reset();
        chk("mf_rst_fill", 32'(fill_level), 32'd0);
        chk("mf_rst_tvalid", 32'(bus_if.out_tvalid), 32'd0);
        bus_if.valid_in = 1'b1;
        bus_if.pixel_in = 24'hF0F0F0;
        step();
        bus_if.valid_in = 1'b0;
        chk("mf_next_tvalid", 32'(bus_if.out_tvalid), 32'd1);
        chk("mf_next_tdata", 32'(bus_if.out_tdata), 32'hF0F0F0);
        chk("mf_next_tuser", 32'(bus_if.out_tuser), 32'd1);
        bus_if.out_tready = 1'b1;
        step();
        chk("mf_consumed", 32'(fill_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
